// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states, byte/word sizes and the
// frame-length check applied to the count byte.
package imem_loader_pkg;

   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned WORD_BYTES = 2;
   localparam int unsigned WORD_W     = BYTE_W * WORD_BYTES;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR  = 3'd1,
      S_HI   = 3'd2,
      S_LO   = 3'd3,
      S_WR   = 3'd4,
      S_CHK  = 3'd5,
      S_DONE = 3'd6,
      S_ERR  = 3'd7
   } state_t;

   // A frame must carry at least one word and no more than the IM holds.
   function automatic logic count_ok(input logic [BYTE_W-1:0] n, input int unsigned addr_w);
      return (n != '0) && (32'(n) <= (32'd1 << addr_w));
   endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Pairs stream bytes into 16-bit words (high byte first) and keeps the running XOR checksum
// of every data byte since the last clear.
module byte_packer
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              nClear,
   input  logic              clear,
   input  logic              load,
   input  logic [BYTE_W-1:0] in_byte,
   output logic              valid,
   output logic [WORD_W-1:0] word,
   output logic [BYTE_W-1:0] checksum
);

   logic              phase_q, phase_d;
   logic [BYTE_W-1:0] hi_q, hi_d;
   logic [BYTE_W-1:0] csum_q, csum_d;

   always_comb begin
      phase_d = phase_q;
      hi_d    = hi_q;
      csum_d  = csum_q;
      if (clear) begin
         phase_d = 1'b0;
         hi_d    = '0;
         csum_d  = '0;
      end else if (load) begin
         csum_d  = csum_q ^ in_byte;
         phase_d = ~phase_q;
         if (!phase_q) begin
            hi_d = in_byte;
         end
      end
   end

   always_ff @(posedge clk or negedge nClear) begin
      if (!nClear) begin
         phase_q <= 1'b0;
         hi_q    <= '0;
         csum_q  <= '0;
      end else begin
         phase_q <= phase_d;
         hi_q    <= hi_d;
         csum_q  <= csum_d;
      end
   end

   // The low byte completes a word in the same cycle it is loaded.
   assign valid    = load & phase_q & ~clear;
   assign word     = {hi_q, in_byte};
   assign checksum = csum_q;

endmodule

// File: rtl/imem_loader.sv
// Streams a counted, XOR-checked program frame from a byte source into the 16-bit instruction
// memory, holding the core in reset until a frame has loaded cleanly.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              nClear,
   input  logic              start,
   input  logic              in_valid,
   input  logic [BYTE_W-1:0] in_byte,
   output logic              in_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [DATA_W-1:0] im_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              err
);

   localparam int unsigned CNT_W = ADDR_W + 1;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  n_q, n_d;
   logic [CNT_W-1:0]  idx_q, idx_d;
   logic [ADDR_W-1:0] im_addr_q, im_addr_d;
   logic [DATA_W-1:0] im_wdata_q, im_wdata_d;
   logic              in_ready_q, in_ready_d;
   logic              im_we_q, im_we_d;
   logic              cpu_hold_q, cpu_hold_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              xfer;
   logic              pk_clear, pk_load, pk_valid;
   logic [WORD_W-1:0] pk_word;
   logic [BYTE_W-1:0] pk_csum;

   byte_packer u_packer (
      .clk      (clk),
      .nClear   (nClear),
      .clear    (pk_clear),
      .load     (pk_load),
      .in_byte  (in_byte),
      .valid    (pk_valid),
      .word     (pk_word),
      .checksum (pk_csum)
   );

   assign xfer = in_valid & in_ready_q;

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      idx_d      = idx_q;
      im_addr_d  = im_addr_q;
      im_wdata_d = im_wdata_q;
      pk_clear   = 1'b0;
      pk_load    = 1'b0;
      case (state_q)
         S_IDLE: if (start) state_d = S_HDR;
         S_HDR: begin
            if (xfer) begin
               if (count_ok(in_byte, ADDR_W)) begin
                  n_d      = CNT_W'(in_byte);
                  idx_d    = '0;
                  pk_clear = 1'b1;
                  state_d  = S_HI;
               end else begin
                  state_d = S_ERR;
               end
            end
         end
         S_HI: begin
            pk_load = xfer;
            if (xfer) state_d = S_LO;
         end
         S_LO: begin
            pk_load = xfer;
            if (pk_valid) begin
               im_addr_d  = idx_q[ADDR_W-1:0];
               im_wdata_d = DATA_W'(pk_word);
               state_d    = S_WR;
            end
         end
         S_WR: begin
            if ((idx_q + CNT_W'(1)) == n_q) begin
               state_d = S_CHK;
            end else begin
               idx_d   = idx_q + CNT_W'(1);
               state_d = S_HI;
            end
         end
         S_CHK: begin
            if (xfer) state_d = (in_byte == pk_csum) ? S_DONE : S_ERR;
         end
         S_DONE, S_ERR: if (start) state_d = S_HDR;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they always describe the current state.
   always_comb begin
      in_ready_d = (state_d == S_HDR) || (state_d == S_HI) || (state_d == S_LO) || (state_d == S_CHK);
      im_we_d    = (state_d == S_WR);
      cpu_hold_d = (state_d != S_DONE);
      done_d     = (state_d == S_DONE);
      err_d      = (state_d == S_ERR);
   end

   always_ff @(posedge clk or negedge nClear) begin
      if (!nClear) begin
         state_q    <= S_IDLE;
         n_q        <= '0;
         idx_q      <= '0;
         im_addr_q  <= '0;
         im_wdata_q <= '0;
         in_ready_q <= 1'b0;
         im_we_q    <= 1'b0;
         cpu_hold_q <= 1'b1;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         idx_q      <= idx_d;
         im_addr_q  <= im_addr_d;
         im_wdata_q <= im_wdata_d;
         in_ready_q <= in_ready_d;
         im_we_q    <= im_we_d;
         cpu_hold_q <= cpu_hold_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign in_ready = in_ready_q;
   assign im_we    = im_we_q;
   assign im_addr  = im_addr_q;
   assign im_wdata = im_wdata_q;
   assign cpu_hold = cpu_hold_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a frame-level model predicts the IM writes and final status,
// and every negedge tick compares the write port and status outputs against it.
module tb_imem_loader;

   localparam int unsigned ADDR_W = 6;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned MAXW   = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              nClear = 1'b0;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_byte = '0;
   logic              in_ready;
   logic              im_we;
   logic [ADDR_W-1:0] im_addr;
   logic [DATA_W-1:0] im_wdata;
   logic              cpu_hold;
   logic              done;
   logic              err;

   imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk      (clk),
      .nClear   (nClear),
      .start    (start),
      .in_valid (in_valid),
      .in_byte  (in_byte),
      .in_ready (in_ready),
      .im_we    (im_we),
      .im_addr  (im_addr),
      .im_wdata (im_wdata),
      .cpu_hold (cpu_hold),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   int unsigned total = 0;
   int unsigned bad = 0;
   int unsigned we_cnt = 0;
   int unsigned exp_addr[$];
   logic [15:0] exp_data[$];
   logic [15:0] shadow[MAXW];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, want);
      end
   endtask

   // One clock of observation: IM writes checked against the model queue, status invariants.
   task automatic tick();
      @(negedge clk);
      if (nClear) begin
         if (im_we) begin
            we_cnt++;
            shadow[im_addr] = im_wdata;
            chk("ready_in_wr", 32'(in_ready), 32'd0);
            if (exp_addr.size() == 0) begin
               chk("unexpected_we", 32'(im_we), 32'd0);
            end else begin
               chk("we_addr", 32'(im_addr), exp_addr.pop_front());
               chk("we_data", 32'(im_wdata), 32'(exp_data.pop_front()));
            end
         end
         chk("hold_vs_done", 32'(cpu_hold), 32'(!done));
         chk("done_and_err", 32'(done & err), 32'd0);
      end
   endtask

   function automatic logic [7:0] xsum(input logic [7:0] f[$]);
      logic [7:0] x = '0;
      for (int unsigned i = 1; i <= 2 * int'(f[0]) && i < f.size(); i++) x ^= f[i];
      return x;
   endfunction

   task automatic model_frame(input logic [7:0] f[$], output bit ok);
      int unsigned n = int'(f[0]);
      exp_addr.delete();
      exp_data.delete();
      ok = 1'b0;
      if (n == 0 || n > MAXW) return;
      for (int unsigned i = 0; i < n; i++) begin
         exp_addr.push_back(i);
         exp_data.push_back({f[1 + 2 * i], f[2 + 2 * i]});
      end
      ok = (f.size() > 2 * n + 1) && (f[2 * n + 1] == xsum(f));
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int unsigned k = 0;
      if (gaps) begin
         in_valid = 1'b0;
         repeat ($urandom_range(0, 2)) tick();
      end
      in_valid = 1'b1;
      in_byte  = b;
      while (!in_ready && k < 100) begin
         tick();
         k++;
      end
      if (!in_ready) begin
         chk("ready_timeout", 32'(in_ready), 32'd1);
         in_valid = 1'b0;
         return;
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic run_frame(input string tag, input logic [7:0] f[$], input bit gaps, input bit mid_start);
      bit ok;
      int unsigned we0, nexp, k;
      model_frame(f, ok);
      nexp = exp_addr.size();
      pulse_start();
      we0 = we_cnt;
      for (int unsigned i = 0; i < f.size(); i++) begin
         send_byte(f[i], gaps);
         if (mid_start && i == 2) pulse_start();
      end
      k = 0;
      while (!(done || err) && k < 8) begin
         tick();
         k++;
      end
      chk({tag, "_done"}, 32'(done), 32'(ok));
      chk({tag, "_err"}, 32'(err), 32'(!ok));
      chk({tag, "_hold"}, 32'(cpu_hold), 32'(!ok));
      chk({tag, "_we_count"}, we_cnt - we0, nexp);
      chk({tag, "_pending"}, exp_addr.size(), 32'd0);
   endtask

   initial begin
      logic [7:0] f1[$];
      logic [7:0] f2[$];
      logic [7:0] f0[$];
      logic [7:0] f65[$];
      logic [7:0] fbig[$];
      bit ok;
      int unsigned we0;

      f1   = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
      f2   = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
      f0   = '{8'h00};
      f65  = '{8'h41};
      fbig = '{8'h40};
      for (int unsigned i = 0; i < 2 * MAXW; i++) fbig.push_back(8'($urandom_range(0, 255)));
      fbig.push_back(xsum(fbig));

      // Model pinned to hand-computed values.
      chk("model_csum_f1", 32'(xsum(f1)), 32'h40);
      model_frame(f2, ok);
      chk("model_f2_bad", 32'(ok), 32'd0);
      chk("model_f2_word1", 32'(exp_data[1]), 32'hABCD);
      exp_addr.delete();
      exp_data.delete();

      repeat (3) tick();
      chk("rst_ready", 32'(in_ready), 32'd0);
      chk("rst_we", 32'(im_we), 32'd0);
      chk("rst_addr", 32'(im_addr), 32'd0);
      chk("rst_wdata", 32'(im_wdata), 32'd0);
      chk("rst_hold", 32'(cpu_hold), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      nClear = 1'b1;
      repeat (2) tick();
      chk("idle_ready", 32'(in_ready), 32'd0);

      run_frame("s1", f1, 1'b0, 1'b0);
      chk("s1_im0", 32'(shadow[0]), 32'h1234);
      chk("s1_im1", 32'(shadow[1]), 32'hABCD);
      chk("s1_done_lit", 32'(done), 32'd1);
      chk("s1_hold_lit", 32'(cpu_hold), 32'd0);

      run_frame("s2", f2, 1'b0, 1'b0);
      chk("s2_err_lit", 32'(err), 32'd1);
      chk("s2_hold_lit", 32'(cpu_hold), 32'd1);

      run_frame("s3_n0", f0, 1'b0, 1'b0);
      run_frame("s3_n65", f65, 1'b0, 1'b0);
      chk("s3_err_lit", 32'(err), 32'd1);

      run_frame("s4", fbig, 1'b0, 1'b0);
      chk("s4_last", 32'(shadow[MAXW-1]), 32'({fbig[2*MAXW-1], fbig[2*MAXW]}));

      run_frame("s5", f1, 1'b1, 1'b1);
      chk("s5_im0", 32'(shadow[0]), 32'h1234);
      chk("s5_im1", 32'(shadow[1]), 32'hABCD);

      // Reset after the third data byte: only IM[0] is written, then a clean reload.
      model_frame(f1, ok);
      pulse_start();
      we0 = we_cnt;
      for (int unsigned i = 0; i < 4; i++) send_byte(f1[i], 1'b0);
      nClear = 1'b0;
      #1;
      chk("s6_ready", 32'(in_ready), 32'd0);
      chk("s6_we", 32'(im_we), 32'd0);
      chk("s6_addr", 32'(im_addr), 32'd0);
      chk("s6_wdata", 32'(im_wdata), 32'd0);
      chk("s6_hold", 32'(cpu_hold), 32'd1);
      chk("s6_done", 32'(done), 32'd0);
      chk("s6_err", 32'(err), 32'd0);
      chk("s6_we_count", we_cnt - we0, 32'd1);
      chk("s6_remaining", exp_addr.size(), 32'd1);
      exp_addr.delete();
      exp_data.delete();
      tick();
      nClear = 1'b1;
      tick();
      run_frame("s6_reload", f1, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
